// File: rtl/pcs_rx_block_lock_if.sv
// Sync-header bus between the RX gearbox and the 64b/66b block-lock controller.
// The gearbox side is the master; the block-lock controller is the slave.
interface pcs_rx_block_lock_if #(
    parameter int SLIP_CNT_WIDTH = 8
);
    logic [1:0]                i_sh;
    logic                      i_sh_valid;
    logic                      o_rx_slip;
    logic                      o_block_lock;
    logic [SLIP_CNT_WIDTH-1:0] o_slip_count;

    modport master (
        output i_sh,
        output i_sh_valid,
        input  o_rx_slip,
        input  o_block_lock,
        input  o_slip_count
    );

    modport slave (
        input  i_sh,
        input  i_sh_valid,
        output o_rx_slip,
        output o_block_lock,
        output o_slip_count
    );
endinterface

// File: rtl/pcs_rx_block_lock.sv
// 64b/66b RX block-lock controller: checks sync headers and pulses a gearbox slip
// until alignment is found, then reports block lock (IEEE 802.3 Clause 49 style).
module pcs_rx_block_lock #(
    parameter int SH_WINDOW        = 64,
    parameter int INVALID_MAX      = 16,
    parameter int SLIP_WAIT_CYCLES = 4,
    parameter int SLIP_CNT_WIDTH   = 8
) (
    input  logic                 gty_rx_usr_clk,
    input  logic                 gty_rx_usr_reset,
    pcs_rx_block_lock_if.slave   bus
);
    localparam int SH_W = $clog2(SH_WINDOW + 1);
    localparam int IV_W = $clog2(INVALID_MAX + 1);
    localparam int WT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_TEST      = 1'b0,
        ST_SLIP_WAIT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [SH_W-1:0]           sh_cnt_q, sh_cnt_d;
    logic [IV_W-1:0]           invld_cnt_q, invld_cnt_d;
    logic [WT_W-1:0]           wait_cnt_q, wait_cnt_d;
    logic                      slip_q, slip_d;
    logic                      lock_q, lock_d;
    logic [SLIP_CNT_WIDTH-1:0] slip_cnt_q, slip_cnt_d;

    logic            sh_invalid;
    logic [SH_W-1:0] sh_n;
    logic [IV_W-1:0] invld_n;
    logic [WT_W-1:0] wait_n;

    assign sh_invalid = (bus.i_sh == 2'b00) || (bus.i_sh == 2'b11);
    assign sh_n       = sh_cnt_q + SH_W'(1);
    assign invld_n    = invld_cnt_q + IV_W'(1);
    assign wait_n     = wait_cnt_q + WT_W'(1);

    always_ff @(posedge gty_rx_usr_clk or posedge gty_rx_usr_reset) begin
        if (gty_rx_usr_reset) begin
            state_q     <= ST_TEST;
            sh_cnt_q    <= '0;
            invld_cnt_q <= '0;
            wait_cnt_q  <= '0;
            slip_q      <= 1'b0;
            lock_q      <= 1'b0;
            slip_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sh_cnt_q    <= sh_cnt_d;
            invld_cnt_q <= invld_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            slip_q      <= slip_d;
            lock_q      <= lock_d;
            slip_cnt_q  <= slip_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_cnt_d    = sh_cnt_q;
        invld_cnt_d = invld_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        slip_d      = 1'b0;
        lock_d      = lock_q;
        slip_cnt_d  = slip_cnt_q;

        case (state_q)
            ST_TEST: begin
                if (bus.i_sh_valid) begin
                    // A slip takes priority over a window ending on the same sample.
                    if (sh_invalid && (!lock_q || invld_n == IV_W'(INVALID_MAX))) begin
                        slip_d      = 1'b1;
                        lock_d      = 1'b0;
                        state_d     = ST_SLIP_WAIT;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        wait_cnt_d  = '0;
                        if (slip_cnt_q != '1) begin
                            slip_cnt_d = slip_cnt_q + SLIP_CNT_WIDTH'(1);
                        end
                    end else if (sh_n == SH_W'(SH_WINDOW)) begin
                        if (invld_cnt_q == '0 && !sh_invalid) begin
                            lock_d = 1'b1;
                        end
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_n;
                        if (sh_invalid) begin
                            invld_cnt_d = invld_n;
                        end
                    end
                end
            end
            ST_SLIP_WAIT: begin
                wait_cnt_d = wait_n;
                if (wait_n == WT_W'(SLIP_WAIT_CYCLES)) begin
                    state_d = ST_TEST;
                end
            end
            default: begin
                state_d = ST_TEST;
            end
        endcase
    end

    assign bus.o_rx_slip    = slip_q;
    assign bus.o_block_lock = lock_q;
    assign bus.o_slip_count = slip_cnt_q;
endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Randomized scenario bench for pcs_rx_block_lock against a sample-level reference
// model of the block-lock rules (window bookkeeping, blind period after each slip).
module tb_pcs_rx_block_lock;
    localparam int SH_WINDOW        = 64;
    localparam int INVALID_MAX      = 16;
    localparam int SLIP_WAIT_CYCLES = 4;
    localparam int SLIP_CNT_WIDTH   = 8;
    localparam int SLIP_SAT         = (1 << SLIP_CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcs_rx_block_lock_if #(.SLIP_CNT_WIDTH(SLIP_CNT_WIDTH)) bus();

    pcs_rx_block_lock #(
        .SH_WINDOW       (SH_WINDOW),
        .INVALID_MAX     (INVALID_MAX),
        .SLIP_WAIT_CYCLES(SLIP_WAIT_CYCLES),
        .SLIP_CNT_WIDTH  (SLIP_CNT_WIDTH)
    ) dut (
        .gty_rx_usr_clk  (clk),
        .gty_rx_usr_reset(rst),
        .bus             (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: outputs after each edge, plus window/blind-period bookkeeping.
    bit m_lock;
    bit m_slip;
    int m_slips;
    int m_blind;
    int m_win;
    int m_bad;

    logic [1:0] pat [SH_WINDOW];

    function automatic logic [1:0] rand_good();
        return ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] rand_bad();
        return ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
    endfunction

    task automatic model_reset();
        m_lock  = 1'b0;
        m_slip  = 1'b0;
        m_slips = 0;
        m_blind = 0;
        m_win   = 0;
        m_bad   = 0;
    endtask

    task automatic model_edge(input logic [1:0] sh, input bit v);
        bit bad;
        bad    = (sh == 2'b00) || (sh == 2'b11);
        m_slip = 1'b0;
        if (m_blind > 0) begin
            m_blind--;
        end else if (v) begin
            if (bad && (!m_lock || m_bad + 1 == INVALID_MAX)) begin
                m_slip  = 1'b1;
                m_lock  = 1'b0;
                if (m_slips < SLIP_SAT) m_slips++;
                m_blind = SLIP_WAIT_CYCLES;
                m_win   = 0;
                m_bad   = 0;
            end else begin
                m_win++;
                if (bad) m_bad++;
                if (m_win == SH_WINDOW) begin
                    if (m_bad == 0) m_lock = 1'b1;
                    m_win = 0;
                    m_bad = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [1:0] sh, input bit v);
        bus.i_sh       = sh;
        bus.i_sh_valid = v;
        @(posedge clk);
        model_edge(sh, v);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.i_sh       = 2'b00;
        bus.i_sh_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic fill_pattern(input int len, input int n_bad);
        logic [1:0] tmp;
        for (int i = 0; i < len; i++) pat[i] = (i < n_bad) ? rand_bad() : rand_good();
        for (int i = len - 1; i > 0; i--) begin
            int j;
            j      = $urandom_range(i, 0);
            tmp    = pat[i];
            pat[i] = pat[j];
            pat[j] = tmp;
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.i_sh       = 2'b00;
        bus.i_sh_valid = 1'b0;
        #1;
        n_checks++; if (bus.o_rx_slip !== 1'b0) $display("FAIL reset_slip got=%0b exp=0", bus.o_rx_slip); else n_pass++;
        n_checks++; if (bus.o_block_lock !== 1'b0) $display("FAIL reset_lock got=%0b exp=0", bus.o_block_lock); else n_pass++;
        n_checks++; if (bus.o_slip_count !== '0) $display("FAIL reset_count got=%0d exp=0", bus.o_slip_count); else n_pass++;
        do_reset();
        $display("test_reset: outputs slip=%0b lock=%0b count=%0d", bus.o_rx_slip, bus.o_block_lock, bus.o_slip_count);
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < SH_WINDOW; i++) begin
            step((i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
            n_checks++; if (bus.o_rx_slip !== 1'b0) $display("FAIL lock_slip i=%0d got=%0b exp=0", i, bus.o_rx_slip); else n_pass++;
            n_checks++; if (bus.o_block_lock !== (i == SH_WINDOW - 1)) $display("FAIL lock_timing i=%0d got=%0b exp=%0b", i, bus.o_block_lock, i == SH_WINDOW - 1); else n_pass++;
        end
        n_checks++; if (bus.o_slip_count !== '0) $display("FAIL lock_count got=%0d exp=0", bus.o_slip_count); else n_pass++;
        $display("test_lock: %0d samples lock=%0b count=%0d", SH_WINDOW, bus.o_block_lock, bus.o_slip_count);
    endtask

    task automatic test_slip_unlocked();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step((i == 10) ? 2'b00 : rand_good(), 1'b1);
            n_checks++; if (bus.o_rx_slip !== (i == 10)) $display("FAIL unl_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, i == 10); else n_pass++;
        end
        for (int i = 0; i < SLIP_WAIT_CYCLES; i++) begin
            step(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            n_checks++; if (bus.o_rx_slip !== 1'b0) $display("FAIL unl_blind i=%0d got=%0b exp=0", i, bus.o_rx_slip); else n_pass++;
        end
        for (int i = 0; i < SH_WINDOW; i++) begin
            step(rand_good(), 1'b1);
            n_checks++; if (bus.o_block_lock !== (i == SH_WINDOW - 1)) $display("FAIL unl_relock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, i == SH_WINDOW - 1); else n_pass++;
            n_checks++; if (bus.o_rx_slip !== m_slip) $display("FAIL unl_model_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, m_slip); else n_pass++;
        end
        n_checks++; if (bus.o_slip_count !== SLIP_CNT_WIDTH'(1)) $display("FAIL unl_count got=%0d exp=1", bus.o_slip_count); else n_pass++;
        $display("test_slip_unlocked: lock=%0b count=%0d", bus.o_block_lock, bus.o_slip_count);
    endtask

    task automatic test_invalid_window();
        int seen;
        do_reset();
        repeat (SH_WINDOW) step(rand_good(), 1'b1);
        fill_pattern(SH_WINDOW, INVALID_MAX - 1);
        for (int i = 0; i < SH_WINDOW; i++) begin
            step(pat[i], 1'b1);
            n_checks++; if (bus.o_rx_slip !== 1'b0 || bus.o_block_lock !== 1'b1) $display("FAIL win15 i=%0d got slip=%0b lock=%0b exp slip=0 lock=1", i, bus.o_rx_slip, bus.o_block_lock); else n_pass++;
        end
        fill_pattern(SH_WINDOW, INVALID_MAX);
        seen = 0;
        for (int i = 0; i < SH_WINDOW && seen < INVALID_MAX; i++) begin
            if (pat[i] == 2'b00 || pat[i] == 2'b11) seen++;
            step(pat[i], 1'b1);
            n_checks++; if (bus.o_rx_slip !== (seen == INVALID_MAX)) $display("FAIL win16_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, seen == INVALID_MAX); else n_pass++;
            n_checks++; if (bus.o_block_lock !== (seen < INVALID_MAX)) $display("FAIL win16_lock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, seen < INVALID_MAX); else n_pass++;
        end
        n_checks++; if (bus.o_slip_count !== SLIP_CNT_WIDTH'(m_slips)) $display("FAIL win16_count got=%0d exp=%0d", bus.o_slip_count, m_slips); else n_pass++;
        $display("test_invalid_window: lock=%0b slip=%0b count=%0d", bus.o_block_lock, bus.o_rx_slip, bus.o_slip_count);
    endtask

    task automatic test_slip_priority();
        do_reset();
        repeat (SH_WINDOW) step(rand_good(), 1'b1);
        fill_pattern(SH_WINDOW - 1, INVALID_MAX - 1);
        pat[SH_WINDOW - 1] = rand_bad();
        for (int i = 0; i < SH_WINDOW; i++) begin
            step(pat[i], 1'b1);
            n_checks++; if (bus.o_rx_slip !== (i == SH_WINDOW - 1)) $display("FAIL prio_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, i == SH_WINDOW - 1); else n_pass++;
            n_checks++; if (bus.o_block_lock !== (i != SH_WINDOW - 1)) $display("FAIL prio_lock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, i != SH_WINDOW - 1); else n_pass++;
        end
        repeat (SLIP_WAIT_CYCLES) step(rand_good(), 1'b1);
        for (int i = 0; i < SH_WINDOW; i++) begin
            step(rand_good(), 1'b1);
            n_checks++; if (bus.o_block_lock !== (i == SH_WINDOW - 1)) $display("FAIL prio_relock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, i == SH_WINDOW - 1); else n_pass++;
        end
        $display("test_slip_priority: lock=%0b count=%0d", bus.o_block_lock, bus.o_slip_count);
    endtask

    task automatic test_strobe_gaps();
        bit v;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(1, 0));
            step((i % 7 == 3) ? 2'b11 : rand_good(), v);
            n_checks++; if (bus.o_rx_slip !== m_slip) $display("FAIL gap_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, m_slip); else n_pass++;
            n_checks++; if (bus.o_slip_count !== SLIP_CNT_WIDTH'(m_slips)) $display("FAIL gap_count i=%0d got=%0d exp=%0d", i, bus.o_slip_count, m_slips); else n_pass++;
            n_checks++; if (bus.o_block_lock !== m_lock) $display("FAIL gap_lock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, m_lock); else n_pass++;
        end
        $display("test_strobe_gaps: 300 cycles count=%0d", bus.o_slip_count);
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(2'b11, 1'b1);
            exp_cnt = (i / (SLIP_WAIT_CYCLES + 1)) + 1;
            if (exp_cnt > SLIP_SAT) exp_cnt = SLIP_SAT;
            n_checks++; if (bus.o_rx_slip !== (i % (SLIP_WAIT_CYCLES + 1) == 0)) $display("FAIL sat_slip i=%0d got=%0b exp=%0b", i, bus.o_rx_slip, i % (SLIP_WAIT_CYCLES + 1) == 0); else n_pass++;
            n_checks++; if (bus.o_slip_count !== SLIP_CNT_WIDTH'(exp_cnt)) $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, bus.o_slip_count, exp_cnt); else n_pass++;
        end
        $display("test_saturate: 2000 cycles count=%0d", bus.o_slip_count);
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) step(rand_good(), 1'b1);
        step(2'b00, 1'b1);
        n_checks++; if (bus.o_rx_slip !== 1'b1) $display("FAIL ar_slip_pre got=%0b exp=1", bus.o_rx_slip); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.o_rx_slip !== 1'b0 || bus.o_slip_count !== '0) $display("FAIL ar_wait got slip=%0b count=%0d exp 0/0", bus.o_rx_slip, bus.o_slip_count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < SH_WINDOW; i++) begin
            step(rand_good(), 1'b1);
            n_checks++; if (bus.o_rx_slip !== 1'b0) $display("FAIL ar_noslip i=%0d got=%0b exp=0", i, bus.o_rx_slip); else n_pass++;
            n_checks++; if (bus.o_block_lock !== (i == SH_WINDOW - 1)) $display("FAIL ar_relock i=%0d got=%0b exp=%0b", i, bus.o_block_lock, i == SH_WINDOW - 1); else n_pass++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.o_block_lock !== 1'b0) $display("FAIL ar_lock got=%0b exp=0", bus.o_block_lock); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (SH_WINDOW) step(rand_good(), 1'b1);
        n_checks++; if (bus.o_block_lock !== 1'b1 || bus.o_slip_count !== '0) $display("FAIL ar_final got lock=%0b count=%0d exp 1/0", bus.o_block_lock, bus.o_slip_count); else n_pass++;
        $display("test_async_reset: lock=%0b count=%0d", bus.o_block_lock, bus.o_slip_count);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_slip_unlocked();
        test_invalid_window();
        test_slip_priority();
        test_strobe_gaps();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pcs_rx_block_lock.md
Name: pcs_rx_block_lock

Overview:
- RX-side controller for the 64b/66b PCS receive path; implements the IEEE 802.3 Clause 49 block-lock state machine.
- Monitors the 2-bit sync header presented by the RX gearbox with each 66-bit block boundary.
- Drives a one-cycle slip request back to the gearbox until header alignment is found, then reports lock to the descrambler/decoder.
- Sits between the RX gearbox and the RX decoder in the gty_rx_usr_clk domain.

Parameters:
- SH_WINDOW, 64, number of header samples per evaluation window.
- INVALID_MAX, 16, invalid headers within one window that cause loss of lock.
- SLIP_WAIT_CYCLES, 4, clock cycles to ignore headers after a slip while the gearbox realigns (>=1).
- SLIP_CNT_WIDTH, 8, width of the saturating slip counter.

Ports:
- gty_rx_usr_clk  in  1  RX user clock; single clock for the whole block.
- gty_rx_usr_reset  in  1  reset, asynchronous, active-high.
- i_sh  in  2  sync header of the current block from the RX gearbox.
- i_sh_valid  in  1  qualifies i_sh; one sample per 66-bit block, with gaps allowed.
- o_rx_slip  out  1  one-cycle slip request to the RX gearbox.
- o_block_lock  out  1  header alignment achieved.
- o_slip_count  out  SLIP_CNT_WIDTH  saturating count of slips since reset.

Behaviour:
- Reset (async assert, release on clock edge):
  - o_rx_slip=0, o_block_lock=0, o_slip_count=0.
  - sh_cnt=0, invld_cnt=0, wait_cnt=0.
  - State=TEST. Any pending slip or wait is discarded.
- Valid header: i_sh==2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11.
- Samples are evaluated only on edges where i_sh_valid=1 and state=TEST. Cycles with i_sh_valid=0 change nothing.
- Counter widths:
  - sh_cnt is clog2(SH_WINDOW+1) bits.
  - invld_cnt is clog2(INVALID_MAX+1) bits.
  - wait_cnt is clog2(SLIP_WAIT_CYCLES+1) bits.
- All outputs are registered; every decision appears on the edge that samples the header.
- States:
  - TEST: evaluates headers.
  - SLIP_WAIT: ignores i_sh/i_sh_valid for SLIP_WAIT_CYCLES cycles.
- Transitions in TEST, per qualified sample (n = sh_cnt+1):
  - Invalid header, o_block_lock=0: o_rx_slip=1 for one cycle, then go to SLIP_WAIT.
  - Invalid header, o_block_lock=1, invld_cnt+1==INVALID_MAX: o_block_lock<=0, o_rx_slip=1, then go to SLIP_WAIT.
  - Otherwise sh_cnt<=n, and invld_cnt increments on an invalid header.
  - If n==SH_WINDOW and no slip is triggered:
    - If the window holds zero invalid headers (including this sample), o_block_lock<=1.
    - Otherwise o_block_lock is unchanged.
    - sh_cnt and invld_cnt clear to 0.
  - Simultaneous window end and slip condition: slip wins and lock drops.
- On entering SLIP_WAIT:
  - o_slip_count increments, saturating at all ones.
  - sh_cnt, invld_cnt clear; wait_cnt loads 0.
- In SLIP_WAIT:
  - o_rx_slip=0.
  - wait_cnt increments each cycle; when it reaches SLIP_WAIT_CYCLES, return to TEST.
  - The first qualified sample may arrive on the following edge.
- Latency:
  - o_block_lock rises on the edge after the SH_WINDOW-th consecutive valid sample is presented, i.e. visible 1 cycle after that sample.
  - o_rx_slip is high for exactly the cycle after the offending sample.
  - Minimum spacing between slip pulses is SLIP_WAIT_CYCLES+1 cycles.
- Once locked, fewer than INVALID_MAX invalid headers per window keeps lock; the count restarts every window.
- o_rx_slip is never asserted while o_block_lock stays 1.

Test Plan:
- Reset release, then 64 valid headers alternating 01/10 with i_sh_valid every cycle -> o_block_lock=1 one cycle after the 64th sample; o_rx_slip never asserted; o_slip_count=0.
- Unlocked, 2'b00 at sample 10 -> single o_rx_slip pulse next cycle; headers ignored for 4 cycles; then 64 valid headers -> lock; o_slip_count=1.
- Locked, 15 invalid headers spread in one 64-window -> lock held, no slip. Next window with 16 invalid -> o_block_lock=0 and o_rx_slip=1 one cycle after the 16th.
- Locked, 16th invalid header is also the 64th sample of the window -> slip and lock loss (slip priority); counters cleared.
- Constant 2'b11 for 2000 cycles -> slip pulses every 5 cycles; o_slip_count saturates at 255 and holds; i_sh_valid toggled 50% -> counters advance only on strobes.
- Assert gty_rx_usr_reset mid-SLIP_WAIT and while locked -> all outputs 0 immediately (asynchronous), no slip after release; relock after 64 valid headers.
